// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide engine: op encodings,
// FSM states and the Booth partial-product select.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULU = 2'b01,
        OP_DIV  = 2'b10,
        OP_DIVU = 2'b11
    } muldiv_op_e;

    typedef enum logic [2:0] {
        IDLE,
        MUL_ITER,
        DIV_ITER,
        FIXUP,
        DONE
    } muldiv_state_e;

    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_sel_t;

endpackage

// File: rtl/booth_r4_recoder.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window {b[i+1], b[i], b[i-1]}
// to a partial-product select of 0, +-1 or +-2 times the multiplicand.
module booth_r4_recoder
    import muldiv_pkg::*;
(
    input  logic [2:0] window,
    output booth_sel_t sel
);

    always_comb begin
        sel = '0;
        case (window)
            3'b001, 3'b010: sel.one = 1'b1;
            3'b011:         sel.two = 1'b1;
            3'b100: begin
                sel.neg = 1'b1;
                sel.two = 1'b1;
            end
            3'b101, 3'b110: begin
                sel.neg = 1'b1;
                sel.one = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/seq_muldiv_unit.sv
// Multi-cycle signed/unsigned MUL (radix-4 Booth) and DIV (restoring) engine.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV ops flag unsupported.
module seq_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int SW    = WIDTH + 3;

    muldiv_state_e state, state_nx;
    logic [CNT_W-1:0]      cnt;
    logic                  accept;
    logic                  iter_last;

    // Booth datapath: acc_hi holds the running upper partial, acc_lo shifts
    // the multiplier out while the product's low bits shift in.
    logic signed [WIDTH:0] mcand_q;
    logic                  mulu_fix_q;
    logic signed [WIDTH:0] acc_hi;
    logic [WIDTH-1:0]      acc_lo;
    logic                  booth_prev;
    booth_sel_t            sel;
    logic signed [SW-1:0]  mcand_ext, pp_mag, pp, corr, mul_sum;
    logic [WIDTH-1:0]      res_hi, res_lo;

`ifdef MULDIV_DIV_EN
    logic [WIDTH-1:0]      dvs_mag_q;
    logic                  is_div_q, q_neg_q, r_neg_q;
    logic [WIDTH:0]        div_shift;
    logic [WIDTH+1:0]      div_trial;

    function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction
`endif

    assign accept    = (state == IDLE) && start;
    assign iter_last = (cnt == CNT_W'(1));
    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = (state == DONE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op[1]) begin
`ifdef MULDIV_DIV_EN
                        state_nx = (b == '0) ? DONE : DIV_ITER;
`else
                        state_nx = DONE;
`endif
                    end else begin
                        state_nx = MUL_ITER;
                    end
                end
            end
            MUL_ITER, DIV_ITER: if (iter_last) state_nx = FIXUP;
            FIXUP:              state_nx = DONE;
            DONE:               state_nx = IDLE;
            default:            state_nx = IDLE;
        endcase
        if (flush && (state != IDLE)) state_nx = IDLE;
    end

    booth_r4_recoder u_recoder (
        .window ({acc_lo[1:0], booth_prev}),
        .sel    (sel)
    );

    // Unsigned multiplier: the digit beyond the top window is b[W-1], worth
    // +mcand * 2^W, folded into the last iteration.
    always_comb begin
        mcand_ext = {{2{mcand_q[WIDTH]}}, mcand_q};
        pp_mag    = sel.two ? (mcand_ext <<< 1) : (sel.one ? mcand_ext : '0);
        pp        = sel.neg ? -pp_mag : pp_mag;
        corr      = (mulu_fix_q && iter_last) ? (mcand_ext <<< 2) : '0;
        mul_sum   = {{2{acc_hi[WIDTH]}}, acc_hi} + pp + corr;
    end

`ifdef MULDIV_DIV_EN
    always_comb begin
        div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        div_trial = {1'b0, div_shift} - {2'b00, dvs_mag_q};
    end
`endif

    always_comb begin
        res_hi = acc_hi[WIDTH-1:0];
        res_lo = acc_lo;
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
            res_hi = apply_sign(acc_hi[WIDTH-1:0], r_neg_q);
            res_lo = apply_sign(acc_lo, q_neg_q);
        end
`endif
    end

    // Control and architectural outputs
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state       <= IDLE;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                div_by_zero <= 1'b0;
                cnt         <= op[1] ? CNT_W'(WIDTH) : CNT_W'(WIDTH / 2);
                if (op[1]) begin
`ifdef MULDIV_DIV_EN
                    if (b == '0) begin
                        hi          <= a;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end
`else
                    hi          <= '0;
                    lo          <= '0;
                    div_by_zero <= 1'b1;
`endif
                end
            end else if ((state == MUL_ITER) || (state == DIV_ITER)) begin
                cnt <= cnt - CNT_W'(1);
            end
            if ((state == FIXUP) && !flush) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

    // Iteration datapath
    always_ff @(posedge clock) begin
        if (accept) begin
            mcand_q    <= op[0] ? {1'b0, a} : {a[WIDTH-1], a};
            mulu_fix_q <= op[0] & b[WIDTH-1];
            acc_hi     <= '0;
            booth_prev <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_q   <= op[1];
            q_neg_q    <= (op == OP_DIV) && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_q    <= (op == OP_DIV) && a[WIDTH-1];
            dvs_mag_q  <= mag_of(b, op == OP_DIV);
            acc_lo     <= op[1] ? mag_of(a, op == OP_DIV) : b;
`else
            acc_lo     <= b;
`endif
        end else if (state == MUL_ITER) begin
            acc_hi     <= mul_sum[WIDTH+2:2];
            acc_lo     <= {mul_sum[1:0], acc_lo[WIDTH-1:2]};
            booth_prev <= acc_lo[1];
        end
`ifdef MULDIV_DIV_EN
        else if (state == DIV_ITER) begin
            acc_hi <= div_trial[WIDTH+1] ? div_shift : div_trial[WIDTH:0];
            acc_lo <= {acc_lo[WIDTH-2:0], ~div_trial[WIDTH+1]};
        end
`endif
    end

endmodule
